// File: rtl/lpc_io_decode.sv
// -----------------------------------------------------------------------------
// lpc_io_decode
//   LPC I/O target that decodes a 32-byte I/O window at BASE_ADDR and turns
//   LPC I/O read/write cycles into a simple register interface.
//
// Parameters
//   BASE_ADDR   I/O base of the 32-byte window (BASE_ADDR[4:0] must be 0)
//
// Ports
//   LpcClock    33 MHz LPC clock, rising edge
//   PciReset    asynchronous active-low reset
//   LpcFrame_N  LFRAME#, active low
//   LadIn       sampled LAD[3:0]
//   RdData      register read data for the current Addr
//   LadOut      registered LAD drive value
//   LadOe       registered LAD output enable, active high
//   Addr        register offset {3'b000, IOaddr[4:0]}
//   Wr          one-clock register write strobe (SYNC clock of a write)
//   DataWrSW    register write data
//
// Build option
//   LPC_SYNC_WAIT_EN  reads insert one short-wait SYNC (4'h5) before SYNC 4'h0
// -----------------------------------------------------------------------------
module lpc_io_decode #(
    parameter logic [15:0] BASE_ADDR = 16'h0800
) (
    input  logic       LpcClock,
    input  logic       PciReset,
    input  logic       LpcFrame_N,
    input  logic [3:0] LadIn,
    input  logic [7:0] RdData,
    output logic [3:0] LadOut,
    output logic       LadOe,
    output logic [7:0] Addr,
    output logic       Wr,
    output logic [7:0] DataWrSW
);

    typedef enum logic [3:0] {
        IDLE,
        CYCTYPE,
        ADDR0,
        ADDR1,
        ADDR2,
        ADDR3,
        WDATA0,
        WDATA1,
        HTAR0,
        HTAR1,
        SYNCWAIT,
        SYNC,
        RDATA0,
        RDATA1,
        PTAR0,
        PTAR1
    } state_t;

    state_t      state;
    state_t      nextState;
    logic [11:0] addrShift;
    logic        isWrite;
    logic [7:0]  rdLatch;
    logic [15:0] fullAddr;
    logic        addrHit;
    logic [3:0]  ladOutNext;
    logic        ladOeNext;
    logic        wrNext;

    // The last address nibble is still on LadIn while in ADDR3.
    always_comb begin
        fullAddr = {addrShift, LadIn};
        addrHit  = (fullAddr[15:5] == BASE_ADDR[15:5]);
    end

    // LAD outputs are registered, so they are derived from the state being
    // entered rather than the current one.
    always_comb begin
        nextState  = state;
        ladOutNext = 4'hF;
        ladOeNext  = 1'b0;
        wrNext     = 1'b0;

        if (state != IDLE && !LpcFrame_N) begin
            // Abort: behaves exactly like a START seen from IDLE.
            nextState = (LadIn == 4'h0) ? CYCTYPE : IDLE;
        end else begin
            case (state)
                IDLE:     if (!LpcFrame_N && LadIn == 4'h0) nextState = CYCTYPE;
                CYCTYPE:  nextState = (LadIn[3:2] == 2'b00) ? ADDR0 : IDLE;
                ADDR0:    nextState = ADDR1;
                ADDR1:    nextState = ADDR2;
                ADDR2:    nextState = ADDR3;
                ADDR3: begin
                    if (!addrHit)     nextState = IDLE;
                    else if (isWrite) nextState = WDATA0;
                    else              nextState = HTAR0;
                end
                WDATA0:   nextState = WDATA1;
                WDATA1:   nextState = HTAR0;
                HTAR0:    nextState = HTAR1;
`ifdef LPC_SYNC_WAIT_EN
                HTAR1:    nextState = isWrite ? SYNC : SYNCWAIT;
`else
                HTAR1:    nextState = SYNC;
`endif
                SYNCWAIT: nextState = SYNC;
                SYNC:     nextState = isWrite ? PTAR0 : RDATA0;
                RDATA0:   nextState = RDATA1;
                RDATA1:   nextState = PTAR0;
                PTAR0:    nextState = PTAR1;
                PTAR1:    nextState = IDLE;
                default:  nextState = IDLE;
            endcase
        end

        case (nextState)
            SYNCWAIT: begin ladOutNext = 4'h5;         ladOeNext = 1'b1; end
            SYNC:     begin ladOutNext = 4'h0;         ladOeNext = 1'b1; wrNext = isWrite; end
            RDATA0:   begin ladOutNext = rdLatch[3:0]; ladOeNext = 1'b1; end
            RDATA1:   begin ladOutNext = rdLatch[7:4]; ladOeNext = 1'b1; end
            PTAR0:    begin ladOutNext = 4'hF;         ladOeNext = 1'b1; end
            default:  begin ladOutNext = 4'hF;         ladOeNext = 1'b0; end
        endcase
    end

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            state  <= IDLE;
            LadOut <= 4'hF;
            LadOe  <= 1'b0;
            Wr     <= 1'b0;
        end else begin
            state  <= nextState;
            LadOut <= ladOutNext;
            LadOe  <= ladOeNext;
            Wr     <= wrNext;
        end
    end

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            addrShift <= '0;
            isWrite   <= 1'b0;
            Addr      <= '0;
            DataWrSW  <= '0;
            rdLatch   <= '0;
        end else begin
            if (state == CYCTYPE) isWrite <= LadIn[1];

            if (state == ADDR0 || state == ADDR1 || state == ADDR2)
                addrShift <= {addrShift[7:0], LadIn};

            if (state == ADDR3 && (nextState == WDATA0 || nextState == HTAR0))
                Addr <= {3'b000, fullAddr[4:0]};

            if (state == WDATA0 && nextState == WDATA1) DataWrSW[3:0] <= LadIn;
            if (state == WDATA1 && nextState == HTAR0)  DataWrSW[7:4] <= LadIn;

            // Latch on entry to the 4'h0 SYNC so RDATA can drive it next clock.
            if (nextState == SYNC && state != SYNC && !isWrite)
                rdLatch <= RdData;
        end
    end

endmodule

// File: tb/tb_lpc_io_decode.sv
// -----------------------------------------------------------------------------
// tb_lpc_io_decode
//   Self-checking bench for lpc_io_decode. Each LPC cycle is driven period by
//   period; the expected LAD/Wr timeline is built from the cycle description
//   (cycle type, address window, data) and compared every bus period.
//   Define LPC_SYNC_WAIT_EN for both bench and RTL to check the wait build.
// -----------------------------------------------------------------------------
module tb_lpc_io_decode;

    localparam int BASE = 'h0800;

    logic       LpcClock = 1'b0;
    logic       PciReset;
    logic       LpcFrame_N;
    logic [3:0] LadIn;
    logic [7:0] RdData;
    logic [3:0] LadOut;
    logic       LadOe;
    logic [7:0] Addr;
    logic       Wr;
    logic [7:0] DataWrSW;

    int compared   = 0;
    int mismatched = 0;
    logic [7:0] modelAddr = 8'h00;

    always #15 LpcClock = ~LpcClock;

    lpc_io_decode #(.BASE_ADDR(16'h0800)) dut (
        .LpcClock  (LpcClock),
        .PciReset  (PciReset),
        .LpcFrame_N(LpcFrame_N),
        .LadIn     (LadIn),
        .RdData    (RdData),
        .LadOut    (LadOut),
        .LadOe     (LadOe),
        .Addr      (Addr),
        .Wr        (Wr),
        .DataWrSW  (DataWrSW)
    );

    // One LPC cycle. Period 0 is the first START period. stopAt >= 0 ends the
    // cycle at that period: either by a new START (caller continues with a
    // chained cycle) or by asserting reset. Chained cycles reuse the current
    // negedge for their period 0.
    task automatic runCycle(input logic [3:0] cyc, input logic [15:0] addr,
                            input logic [7:0] wdata, input logic [7:0] rdata,
                            input int nStart, input int stopAt,
                            input bit stopReset, input bit chained);
        logic       expOe  [32];
        logic [3:0] expLad [32];
        logic       expWr  [32];
        int         off, n, p, k;
        bit         isWr, hit;
        logic [7:0] offset, newAddr;

        off    = nStart - 1;
        n      = 14 + off;
        isWr   = (cyc >= 2 && cyc < 4);
        hit    = (cyc < 4) && (int'(addr) >= BASE) && (int'(addr) <= BASE + 31);
        offset = 8'(int'(addr) - BASE);
        for (int i = 0; i < 32; i++) begin
            expOe[i] = 1'b0; expLad[i] = 4'hF; expWr[i] = 1'b0;
        end
        if (hit && !isWr) begin
            p = 8 + off;
`ifdef LPC_SYNC_WAIT_EN
            expOe[p] = 1'b1; expLad[p] = 4'h5; p++;
`endif
            expOe[p]   = 1'b1; expLad[p]   = 4'h0;
            expOe[p+1] = 1'b1; expLad[p+1] = 4'(rdata % 16);
            expOe[p+2] = 1'b1; expLad[p+2] = 4'(rdata / 16);
            expOe[p+3] = 1'b1; expLad[p+3] = 4'hF;
        end
        if (hit && isWr) begin
            p = 10 + off;
            expOe[p]   = 1'b1; expLad[p]   = 4'h0; expWr[p] = 1'b1;
            expOe[p+1] = 1'b1; expLad[p+1] = 4'hF;
        end
        newAddr = (hit && (stopAt < 0 || stopAt > nStart + 4)) ? offset : modelAddr;
        RdData  = rdata;

        for (int i = 0; i < n; i++) begin
            if (!(chained && i == 0)) begin
                @(negedge LpcClock);
                compared++;
                if (LadOe !== expOe[i]) begin
                    mismatched++;
                    $display("FAIL LadOe a=%h p%0d: got %b expected %b", addr, i, LadOe, expOe[i]);
                end
                if (expOe[i]) begin
                    compared++;
                    if (LadOut !== expLad[i]) begin
                        mismatched++;
                        $display("FAIL LadOut a=%h p%0d: got %h expected %h", addr, i, LadOut, expLad[i]);
                    end
                end
                compared++;
                if (Wr !== expWr[i]) begin
                    mismatched++;
                    $display("FAIL Wr a=%h p%0d: got %b expected %b", addr, i, Wr, expWr[i]);
                end
                if (expWr[i]) begin
                    compared += 2;
                    if (Addr !== offset) begin
                        mismatched++;
                        $display("FAIL WrAddr a=%h: got %h expected %h", addr, Addr, offset);
                    end
                    if (DataWrSW !== wdata) begin
                        mismatched++;
                        $display("FAIL WrData a=%h: got %h expected %h", addr, DataWrSW, wdata);
                    end
                end
            end
            if (i == stopAt) begin
                if (stopReset) begin
                    PciReset = 1'b0; LpcFrame_N = 1'b1; LadIn = 4'hF;
                    #1;
                    compared += 5;
                    if (LadOe !== 1'b0 || LadOut !== 4'hF || Wr !== 1'b0 ||
                        Addr !== 8'h00 || DataWrSW !== 8'h00) begin
                        mismatched++;
                        $display("FAIL asyncReset: got oe=%b lad=%h wr=%b addr=%h data=%h expected 0 f 0 00 00",
                                 LadOe, LadOut, Wr, Addr, DataWrSW);
                    end
                    modelAddr = 8'h00;
                end else begin
                    LpcFrame_N = 1'b0; LadIn = 4'h0;
                    modelAddr = newAddr;
                end
                return;
            end
            if (i < nStart) begin
                LpcFrame_N = 1'b0; LadIn = 4'h0;
            end else begin
                LpcFrame_N = 1'b1;
                if (i == nStart)                     LadIn = cyc;
                else if (i <= nStart + 4) begin
                    k = i - nStart - 1;
                    LadIn = 4'((int'(addr) >> (12 - 4 * k)) % 16);
                end
                else if (isWr && i == nStart + 5)    LadIn = 4'(wdata % 16);
                else if (isWr && i == nStart + 6)    LadIn = 4'(wdata / 16);
                else                                 LadIn = 4'hF;
            end
        end
        modelAddr = newAddr;
        compared++;
        if (Addr !== modelAddr) begin
            mismatched++;
            $display("FAIL AddrHold a=%h: got %h expected %h", addr, Addr, modelAddr);
        end
    endtask

    task automatic test_reset();
        PciReset = 1'b0; LpcFrame_N = 1'b1; LadIn = 4'hF; RdData = 8'h00;
        repeat (2) @(negedge LpcClock);
        compared += 5;
        if (LadOe !== 1'b0 || LadOut !== 4'hF || Wr !== 1'b0 ||
            Addr !== 8'h00 || DataWrSW !== 8'h00) begin
            mismatched++;
            $display("FAIL reset: got oe=%b lad=%h wr=%b addr=%h data=%h expected 0 f 0 00 00",
                     LadOe, LadOut, Wr, Addr, DataWrSW);
        end
        PciReset = 1'b1;
        repeat (2) @(negedge LpcClock);
        compared++;
        if (LadOe !== 1'b0) begin
            mismatched++;
            $display("FAIL idleOe: got %b expected 0", LadOe);
        end
    endtask

    task automatic test_directed();
        runCycle(4'h2, 16'h0808, 8'h5A, 8'h00, 1, -1, 0, 0);  // write hit
        runCycle(4'h0, 16'h081F, 8'h00, 8'hC3, 1, -1, 0, 0);  // read top of window
        runCycle(4'h2, 16'h0820, 8'h77, 8'h00, 1, -1, 0, 0);  // just above window
        runCycle(4'h4, 16'h0808, 8'h00, 8'h99, 1, -1, 0, 0);  // memory read
        runCycle(4'h0, 16'h07FF, 8'h00, 8'h11, 1, -1, 0, 0);  // just below window
        runCycle(4'h0, 16'h0800, 8'h00, 8'h3C, 1, -1, 0, 0);  // base of window
    endtask

    task automatic test_start_rule();
        runCycle(4'h3, 16'h0815, 8'hE1, 8'h00, 3, -1, 0, 0);  // repeated START
        runCycle(4'h1, 16'h0802, 8'h00, 8'h6B, 2, -1, 0, 0);
    endtask

    task automatic test_abort();
        runCycle(4'h2, 16'h0808, 8'h5A, 8'h00, 1, 7, 0, 0);   // abort in 2nd WDATA
        runCycle(4'h2, 16'h0811, 8'hA5, 8'h00, 1, -1, 0, 1);
        runCycle(4'h0, 16'h0813, 8'h00, 8'h4E, 1, 9, 0, 0);   // abort while driving
        runCycle(4'h0, 16'h081E, 8'h00, 8'hD2, 1, -1, 0, 1);
    endtask

    task automatic test_reset_mid();
        runCycle(4'h0, 16'h081F, 8'h00, 8'hC3, 1, 9, 1, 0);
        repeat (2) @(negedge LpcClock);
        PciReset = 1'b1;
        runCycle(4'h0, 16'h0805, 8'h00, 8'h81, 1, -1, 0, 0);
        runCycle(4'h2, 16'h0806, 8'h42, 8'h00, 1, -1, 0, 0);
    endtask

    task automatic test_random();
        logic [3:0]  cyc;
        logic [15:0] addr;
        int          sel, stopAt;
        bit          chain;
        chain = 0;
        for (int t = 0; t < 40; t++) begin
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      cyc = {3'b000, 1'($urandom)};
            else if (sel == 1) cyc = {3'b001, 1'($urandom)};
            else               cyc = {3'($urandom_range(2, 7)), 1'($urandom)};
            addr   = 16'(BASE - 16 + int'($urandom_range(0, 63)));
            stopAt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 13)) : -1;
            runCycle(cyc, addr, 8'($urandom), 8'($urandom),
                     int'($urandom_range(1, 2)), stopAt, 0, chain);
            chain = (stopAt >= 0);
        end
        if (chain) runCycle(4'h0, 16'h0810, 8'h00, 8'h5D, 1, -1, 0, 1);
    endtask

    task automatic test_back_to_back();
        runCycle(4'h2, 16'h0801, 8'h10, 8'h00, 1, -1, 0, 0);
        runCycle(4'h0, 16'h0801, 8'h00, 8'hF0, 1, -1, 0, 0);
        runCycle(4'h2, 16'h081F, 8'hFF, 8'h00, 1, -1, 0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_rule();
        test_abort();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lpc_io_decode.md
LPC_IO_DECODE -- requirements
Module: lpc_io_decode

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 16'h0800, giving the I/O base of a 32-byte decode window (BASE_ADDR[4:0] = 0).
REQ-002 The block SHALL have port LpcClock, input, 1, the 33 MHz LPC clock; all state updates on its rising edge.
REQ-003 The block SHALL have port PciReset, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port LpcFrame_N, input, 1, the LPC LFRAME#, active low.
REQ-005 The block SHALL have port LadIn, input, 4, the sampled LAD[3:0] bus.
REQ-006 The block SHALL have port RdData, input, 8, the register read data for the current Addr.
REQ-007 The block SHALL have port LadOut, output, 4, the LAD drive value.
REQ-008 The block SHALL have port LadOe, output, 1, the LAD output enable, active high.
REQ-009 The block SHALL have port Addr, output, 8, the register offset: {3'b000, IOaddr[4:0]}.
REQ-010 The block SHALL have port Wr, output, 1, a one-clock register write strobe.
REQ-011 The block SHALL have port DataWrSW, output, 8, the register write data.

Function
REQ-012 The FSM SHALL use states IDLE, CYCTYPE, ADDR (4 nibbles), WDATA (2 nibbles), HTAR (2), SYNC, RDATA (2), PTAR (2).
REQ-013 IDLE->CYCTYPE SHALL occur on a clock with LpcFrame_N=0 and LadIn=4'h0; while LpcFrame_N stays low, each clock with LadIn=4'h0 re-enters CYCTYPE.
REQ-014 In CYCTYPE, LadIn[3:1]=3'b000 (I/O read) or 3'b001 (I/O write) SHALL go to ADDR; any other value SHALL go to IDLE with no bus drive.
REQ-015 ADDR SHALL capture 16 address bits, MSB nibble first, over 4 clocks.
REQ-016 If the captured address is outside BASE_ADDR..BASE_ADDR+31, the FSM SHALL return to IDLE; LadOe SHALL stay 0 and Wr SHALL stay 0.
REQ-017 On a decoded hit, Addr SHALL update on the clock after the last address nibble and hold until the next hit.
REQ-018 For a write, WDATA SHALL capture the low nibble then the high nibble into DataWrSW; the FSM SHALL then pass through HTAR (2 clocks, LadOe=0) and enter SYNC.
REQ-019 For a read, the FSM SHALL go from ADDR directly to HTAR (2 clocks), then to SYNC.
REQ-020 In SYNC, the block SHALL drive LadOut=4'h0 with LadOe=1 for one clock.
REQ-021 On a write, Wr SHALL be 1 for exactly the SYNC clock; DataWrSW and Addr SHALL be stable while Wr=1.
REQ-022 On a read, RdData SHALL be latched on entry to SYNC, then driven as the low nibble and then the high nibble in RDATA, with LadOe=1.
REQ-023 PTAR SHALL drive LadOut=4'hF with LadOe=1 for the first clock, and LadOe=0 for the second, then return to IDLE.
REQ-024 LadOut and LadOe SHALL be registered outputs.
REQ-025 LpcFrame_N=0 in any non-IDLE state SHALL abort the cycle: LadOe=0 from the next edge, no Wr, and the FSM SHALL follow the START rule of REQ-013.
REQ-026 Total read latency from START SHALL be 12 clocks (START, CYC, 4 ADDR, 2 HTAR, SYNC, 2 RDATA, PTAR1), with no wait states.

Reset
REQ-027 While PciReset=0, the FSM SHALL be IDLE, with LadOut=4'hF, LadOe=0, Addr=8'h00, Wr=0, DataWrSW=8'h00 and the read latch=8'h00.
REQ-028 Reset asserted mid-cycle SHALL release LAD immediately (asynchronously), and SHALL suppress any pending Wr.

Configuration
REQ-029 With macro LPC_SYNC_WAIT_EN defined, read cycles SHALL insert one SYNC clock of 4'h5 (short wait) before the 4'h0 SYNC; RdData SHALL be latched on the 4'h0 SYNC clock; read latency SHALL be 13 clocks.
REQ-030 Without LPC_SYNC_WAIT_EN, there SHALL be no wait SYNC; write cycles SHALL be identical in both builds.

Verification
REQ-031 I/O write 0x0808, data 0x5A -> one Wr pulse during SYNC with Addr=8'h08 and DataWrSW=8'h5A; LAD sequence 0,F,Z.
REQ-032 I/O read 0x081F with RdData=8'hC3 -> LAD driven 0,3,C,F, then Z; no Wr.
REQ-033 I/O write 0x0820 (outside the window), and memory-read cycle type -> LadOe never 1, Wr never 1, Addr unchanged.
REQ-034 LpcFrame_N pulled low with LadIn=0 during the second WDATA nibble -> no Wr; the new cycle that follows decodes correctly.
REQ-035 PciReset asserted during RDATA -> LadOe=0 immediately, all outputs at their reset values; the next cycle after release decodes correctly.
REQ-036 With LPC_SYNC_WAIT_EN defined, the read of REQ-032 -> LAD driven 5,0,3,C,F.
